// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the slide-switch debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// CLK_HZ / DEBOUNCE_MS give the board default settle time, which sets
// STABLE_CYCLES_DEF (20 ms at 50 MHz = 1_000_000 cycles).
package sw_debounce_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DEBOUNCE_MS       = 20;
  localparam int STABLE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Per-edge action taken by a single-bit debouncer.
  typedef enum logic [1:0] {
    CNT_CLEAR  = 2'd0,  // synchronized input agrees with debounced level
    CNT_INC    = 2'd1,  // disagrees, not yet stable long enough
    CNT_ACCEPT = 2'd2   // disagreed for STABLE_CYCLES edges: take new level
  } cnt_op_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: 2-flop synchronizer, stability counter, debounced flop.
// Latency: a held level change reaches sw_db STABLE_CYCLES+2 edges after first sampled.
// Backpressure: none; free-running on every clock.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   sw     - raw asynchronous switch level
//   sw_db  - debounced, registered level
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_db
);

  localparam int             CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  cnt_op_e       op;

  // Counter only ever runs while sync2 disagrees with sw_db; any agreement
  // (a bounce back) restarts it, so it never exceeds CNT_LAST.
  always_comb begin
    op = CNT_CLEAR;
    if (sync2 != sw_db) begin
      op = (cnt == CNT_LAST) ? CNT_ACCEPT : CNT_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      sw_db <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      case (op)
        CNT_CLEAR:  cnt <= '0;
        CNT_INC:    cnt <= cnt + 1'b1;
        CNT_ACCEPT: begin
          cnt   <= '0;
          sw_db <= sync2;
        end
        default:    cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches feeding the half-adder operands; optional change strobe.
// Latency: SW_DB follows a held SW change after STABLE_CYCLES+2 edges; SW_CHG one edge later.
// Backpressure: none; outputs are free-running registers.
//
// Ports:
//   CLOCK_50 - 50 MHz system clock
//   KEY0     - asynchronous active-low reset (pushbutton)
//   SW       - raw bouncing switch levels
//   SW_DB    - debounced switch levels
//   SW_CHG   - one-cycle strobe the cycle after any SW_DB bit changed
// Build option: define SW_DEBOUNCE_CHG_EN to enable SW_CHG; otherwise it is tied low.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic             SW_CHG
);

  generate
    if (STABLE_CYCLES < 2 || WIDTH < 1) begin : g_param_err
      $error("sw_debounce: STABLE_CYCLES must be >= 2 and WIDTH >= 1");
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk   (CLOCK_50),
      .rst_n (KEY0),
      .sw    (SW[i]),
      .sw_db (SW_DB[i])
    );
  end

`ifdef SW_DEBOUNCE_CHG_EN
  // SW_DB delayed by one edge; the xor is nonzero for exactly the cycle
  // following an update, and registering it yields the strobe. Both
  // registers clear together on reset, so reset never fakes a change.
  logic [WIDTH-1:0] sw_db_q;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sw_db_q <= '0;
      SW_CHG  <= 1'b0;
    end else begin
      sw_db_q <= SW_DB;
      SW_CHG  <= |(SW_DB ^ sw_db_q);
    end
  end
`else
  assign SW_CHG = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (WIDTH=2, STABLE_CYCLES=4).
// Reference: a level is accepted once the last STABLE_CYCLES synchronizer
// outputs (raw samples delayed two edges) all differ from the debounced level.
module tb_sw_debounce;

  localparam int WIDTH = 2;
  localparam int SC    = 4;

`ifdef SW_DEBOUNCE_CHG_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif
  localparam logic [31:0] EXP_PULSE = CHG_EN ? 32'd1 : 32'd0;

  logic             clk;
  logic             key0;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic             sw_chg;

  int checks;
  int errors;
  int chg_pulses;

  // reference model state
  logic [WIDTH-1:0] hist[$];   // hist[0] = SW sampled at previous edge
  logic [WIDTH-1:0] m_db;
  logic             m_flag;    // a debounced bit changed at the last edge
  logic             m_chg;

  sw_debounce #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (SC)
  ) dut (
    .CLOCK_50 (clk),
    .KEY0     (key0),
    .SW       (sw),
    .SW_DB    (sw_db),
    .SW_CHG   (sw_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_db   = '0;
    m_flag = 1'b0;
    m_chg  = 1'b0;
    hist   = {};
    for (int i = 0; i < SC + 2; i++) hist.push_back('0);
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] sample);
    logic [WIDTH-1:0] nd;
    bit               all_diff;
    nd = m_db;
    for (int b = 0; b < WIDTH; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < SC; j++)
        if (hist[1 + j][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_db[b];
    end
    m_chg  = m_flag;
    m_flag = (nd != m_db);
    m_db   = nd;
    hist.push_front(sample);
    void'(hist.pop_back());
  endtask

  // One rising edge: advance model, then compare #1 after the edge.
  task automatic tick();
    @(posedge clk);
    if (!key0) model_reset();
    else       model_edge(sw);
    #1;
    check("db_model", 32'(sw_db), 32'(m_db));
    check("chg_model", 32'(sw_chg), 32'(CHG_EN ? m_chg : 1'b0));
    if (sw_chg === 1'b1) chg_pulses++;
  endtask

  task automatic settle(input logic [WIDTH-1:0] v);
    sw = v;
    repeat (12) tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    chg_pulses = 0;
    key0       = 1'b1;
    sw         = '0;
    model_reset();

    // reset held with switches high
    #2;
    key0 = 1'b0;
    sw   = 2'b11;
    model_reset();
    repeat (10) begin
      tick();
      check("rst_db", 32'(sw_db), 32'h0);
      check("rst_chg", 32'(sw_chg), 32'h0);
    end
    key0 = 1'b1;

    // clean step 00 -> 01
    settle(2'b00);
    sw = 2'b01;
    chg_pulses = 0;
    repeat (5) tick();
    check("step_db_e5", 32'(sw_db), 32'h0);
    tick();
    check("step_db_e6", 32'(sw_db), 32'h1);
    check("step_chg_e6", 32'(sw_chg), 32'h0);
    tick();
    check("step_chg_e7", 32'(sw_chg), EXP_PULSE);
    tick();
    check("step_chg_e8", 32'(sw_chg), 32'h0);
    check("step_pulses", 32'(chg_pulses), EXP_PULSE);

    // bounce on bit 0: 1,1,0,0 then held 1
    settle(2'b00);
    chg_pulses = 0;
    sw = 2'b01; repeat (2) tick();
    sw = 2'b00; repeat (2) tick();
    sw = 2'b01;
    repeat (5) tick();
    check("bounce_db_e5", 32'(sw_db), 32'h0);
    tick();
    check("bounce_db_e6", 32'(sw_db), 32'h1);
    repeat (3) tick();
    check("bounce_pulses", 32'(chg_pulses), EXP_PULSE);

    // simultaneous 00 -> 11
    settle(2'b00);
    chg_pulses = 0;
    sw = 2'b11;
    repeat (5) tick();
    check("simul_db_e5", 32'(sw_db), 32'h0);
    tick();
    check("simul_db_e6", 32'(sw_db), 32'h3);
    repeat (3) tick();
    check("simul_pulses", 32'(chg_pulses), EXP_PULSE);

    // reset mid-count
    settle(2'b00);
    chg_pulses = 0;
    sw = 2'b10;
    repeat (4) tick();
    key0 = 1'b0;
    model_reset();
    #1;
    check("midrst_db_async", 32'(sw_db), 32'h0);
    check("midrst_chg_async", 32'(sw_chg), 32'h0);
    tick();
    key0 = 1'b1;
    repeat (5) tick();
    check("midrst_db_e5", 32'(sw_db), 32'h0);
    tick();
    check("midrst_db_e6", 32'(sw_db), 32'h2);
    repeat (3) tick();
    check("midrst_pulses", 32'(chg_pulses), EXP_PULSE);

    // randomized holds of 1..8 cycles with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        key0 = 1'b0;
        model_reset();
        tick();
        key0 = 1'b1;
      end
      sw = WIDTH'($urandom);
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 2: number of slide switches debounced; operand bits for the downstream half adder.
REQ-002 Parameter STABLE_CYCLES, default 1_000_000: cycles a synchronized input must differ from its debounced value before it is accepted (20 ms at 50 MHz); legal range ≥2.
REQ-003 CLOCK_50  input  1  system clock, 50 MHz board oscillator.
REQ-004 KEY0  input  1  reset; asynchronous, active-low (pushbutton KEY[0]).
REQ-005 SW  input  WIDTH  raw, asynchronous, bouncing slide switch levels.
REQ-006 SW_DB  output  WIDTH  debounced, synchronous switch levels; drives the half-adder operand inputs.
REQ-007 SW_CHG  output  1  one-cycle strobe, high in the cycle after any SW_DB bit changes.

Function
REQ-008 Each SW bit SHALL pass through a two-flop synchronizer (sync1, sync2) clocked by CLOCK_50 before any other use.
REQ-009 Each bit SHALL own an independent counter of width $clog2(STABLE_CYCLES), saturating never, clearing on match.
REQ-010 Per bit, per edge: if sync2 == SW_DB bit, counter <= 0.
REQ-011 Per bit, per edge: if sync2 != SW_DB bit and counter < STABLE_CYCLES-1, counter <= counter+1.
REQ-012 Per bit, per edge: if sync2 != SW_DB bit and counter == STABLE_CYCLES-1, SW_DB bit <= sync2 and counter <= 0.
REQ-013 Latency: a SW level change held stable SHALL appear on SW_DB exactly STABLE_CYCLES+2 rising edges after the first edge sampling it.
REQ-014 Bounce: any return of sync2 to the SW_DB value before acceptance SHALL clear the counter; SW_DB SHALL not change.
REQ-015 Bits SHALL be fully independent; simultaneous acceptance on several bits SHALL update them on the same edge.
REQ-016 SW_CHG SHALL be high for exactly one cycle per edge on which ≥1 SW_DB bit changed (registered, one cycle after the update), regardless of how many bits changed.
REQ-017 SW_DB SHALL be glitch-free register outputs; no combinational path from SW to any output.

Reset
REQ-018 KEY0 low SHALL asynchronously clear sync1, sync2, all counters, SW_DB (0) and SW_CHG (0).
REQ-019 Reset asserted mid-count SHALL abandon the count; after release, counting restarts from 0 with no SW_CHG pulse generated by reset itself.
REQ-020 Reset release is assumed synchronized externally; first valid sampling is the first rising edge after KEY0 goes high.

Configuration
REQ-021 Macro SW_DEBOUNCE_CHG_EN: when defined, SW_CHG behaves per REQ-016.
REQ-022 When SW_DEBOUNCE_CHG_EN is undefined, SW_CHG SHALL be tied to 0, its register omitted; port list unchanged; SW_DB behaviour identical.

Structure
REQ-023 Shared package/include SHALL hold CLK_HZ (50_000_000), DEBOUNCE_MS (20) and the derived default STABLE_CYCLES.
REQ-024 One sub-module debounce_bit (synchronizer + counter + debounced flop for a single bit) SHALL be instantiated WIDTH times via generate; sw_debounce adds only the SW_CHG logic.
REQ-025 Elaboration SHALL fail (parameter check) if STABLE_CYCLES < 2 or WIDTH < 1.

Verification (bench uses STABLE_CYCLES=4, WIDTH=2)
REQ-026 Reset: KEY0=0 with SW=2'b11 for 10 cycles -> SW_DB=2'b00, SW_CHG=0 throughout.
REQ-027 Clean step: SW 00->01 held -> SW_DB=01 exactly on 6th edge, SW_CHG high for one cycle on 7th edge, then 0.
REQ-028 Bounce: SW[0] toggles 0->1->0->1 each lasting 2 cycles, then held 1 -> SW_DB[0] changes only 6 edges after final stable 1; single SW_CHG pulse.
REQ-029 Simultaneous: SW 00->11 on one edge -> both SW_DB bits update on same edge to 11; exactly one SW_CHG pulse.
REQ-030 Reset mid-count: SW 00->10, KEY0 pulsed low at edge 4 for 1 cycle -> SW_DB stays 00 through reset, becomes 10 on 6th edge after release, no extra SW_CHG.
REQ-031 Macro off: repeat REQ-027 without SW_DEBOUNCE_CHG_EN -> SW_DB timing identical, SW_CHG constantly 0.
